regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Request-side bus of the register-file write arbiter: four packed requesters
// plus a global stall, with the combinational one-hot grant returned.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned NUM_REQ = 4;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          stall;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid, req_addr, req_data, stall,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
    output req_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging four write requesters onto one register-file
// write port; writes to register 0 are discarded and counted.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  regfile_write_arbiter_if.slave req_bus,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [1:0]            grant_id,
  output logic [7:0]            drop_count
);
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [PTR_W-1:0]      gid_q, gid_d;
  logic [CNT_W-1:0]      drop_q, drop_d;

  logic                  found_c;
  logic                  xfer_c;
  logic [PTR_W-1:0]      win_c;
  logic [PTR_W-1:0]      idx_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic [DATA_WIDTH-1:0] win_data_c;

  // First valid requester in rotating order starting at ptr
  always_comb begin
    found_c = 1'b0;
    win_c   = ptr_q;
    idx_c   = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_c = PTR_W'(ptr_q + PTR_W'(k));
      if (!found_c && req_bus.req_valid[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
    xfer_c = found_c && !req_bus.stall && !ctrl_reset;
    req_bus.req_ready = xfer_c ? (NUM_REQ'(1) << win_c) : '0;
  end

  assign win_addr_c = req_bus.req_addr[ADDR_WIDTH*win_c +: ADDR_WIDTH];
  assign win_data_c = req_bus.req_data[DATA_WIDTH*win_c +: DATA_WIDTH];

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    drop_d  = drop_q;
    if (xfer_c) begin
      ptr_d   = PTR_W'(win_c + PTR_W'(1));
      we_d    = (win_addr_c != '0);
      wreg_d  = win_addr_c;
      wdata_d = win_data_c;
      gid_d   = win_c;
      // Register 0 is hardwired; count the discarded write, saturating
      if ((win_addr_c == '0) && (drop_q != CNT_MAX)) begin
        drop_d = CNT_W'(drop_q + CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      drop_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      drop_q  <= drop_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign grant_id         = gid_q;
  assign drop_count       = drop_q;
endmodule
